// File: rtl/ir_pipeline_ctrl.sv
// D/E/M/W instruction and PC+8 register chain with the load-use / early-branch stall generator.
// Optional STALL_COUNTER_EN adds a saturating stall_cnt output.
module ir_pipeline_ctrl #(
  parameter logic [31:0] NOP_WORD     = 32'h00000000,
  parameter logic [4:0]  JAL_LINK_REG = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_F,
  input  logic [31:0] PC8_F,
  output logic [31:0] IR_D,
  output logic [31:0] IR_E,
  output logic [31:0] IR_M,
  output logic [31:0] IR_W,
  output logic [31:0] PC8_D,
  output logic [31:0] PC8_E,
  output logic [31:0] PC8_M,
  output logic [31:0] PC8_W,
  output logic        stall,
  output logic        pc_en
`ifdef STALL_COUNTER_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  function automatic logic is_cal_r_fn(input logic [5:0] fn);
    case (fn)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
      6'h26, 6'h27, 6'h2a, 6'h2b: is_cal_r_fn = 1'b1;
      default:                    is_cal_r_fn = 1'b0;
    endcase
  endfunction

  function automatic logic is_ld(input logic [31:0] ir);
    case (ir[31:26])
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: is_ld = 1'b1;
      default:                           is_ld = 1'b0;
    endcase
  endfunction

  function automatic logic is_st(input logic [31:0] ir);
    case (ir[31:26])
      6'h28, 6'h29, 6'h2b: is_st = 1'b1;
      default:             is_st = 1'b0;
    endcase
  endfunction

  function automatic logic is_cal_i(input logic [31:0] ir);
    case (ir[31:26])
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: is_cal_i = 1'b1;
      default:                                         is_cal_i = 1'b0;
    endcase
  endfunction

  // Instructions resolved in D (branches, JR, JALR) need their operands one stage early.
  function automatic logic is_ctrl(input logic [31:0] ir);
    case (ir[31:26])
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: is_ctrl = 1'b1;
      6'h00:   is_ctrl = (ir[5:0] == 6'h08) || (ir[5:0] == 6'h09);
      default: is_ctrl = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs(input logic [31:0] ir);
    if (ir[31:26] == 6'h00)
      uses_rs = (is_cal_r_fn(ir[5:0]) && ir[5:2] != 4'b0000) ||
                (ir[5:0] == 6'h08) || (ir[5:0] == 6'h09);
    else
      uses_rs = is_ld(ir) || is_st(ir) || is_cal_i(ir) || is_ctrl(ir);
  endfunction

  function automatic logic uses_rt(input logic [31:0] ir);
    if (ir[31:26] == 6'h00)
      uses_rt = is_cal_r_fn(ir[5:0]);
    else
      uses_rt = is_st(ir) || (ir[31:26] == 6'h04) || (ir[31:26] == 6'h05);
  endfunction

  function automatic logic [4:0] dest(input logic [31:0] ir);
    dest = 5'd0;
    if (ir[31:26] == 6'h00) begin
      if (is_cal_r_fn(ir[5:0]) || ir[5:0] == 6'h10 || ir[5:0] == 6'h12 || ir[5:0] == 6'h09)
        dest = ir[15:11];
    end else if (is_ld(ir) || is_cal_i(ir) || ir[31:26] == 6'h0f) begin
      dest = ir[20:16];
    end else if (ir[31:26] == 6'h03) begin
      dest = JAL_LINK_REG;
    end
  endfunction

  logic [4:0] d_rs, d_rt, e_dest, m_rt, e_rt;
  logic       d_use_rs, d_use_rt, d_ctrl, d_st;
  logic       e_hit, e_ld_rs_hit, e_ld_rt_hit, m_hit;
  logic       stall_a, stall_b, stall_c;

  assign d_rs     = IR_D[25:21];
  assign d_rt     = IR_D[20:16];
  assign d_use_rs = uses_rs(IR_D);
  assign d_use_rt = uses_rt(IR_D);
  assign d_ctrl   = is_ctrl(IR_D);
  assign d_st     = is_st(IR_D);
  assign e_dest   = dest(IR_E);
  assign e_rt     = IR_E[20:16];
  assign m_rt     = IR_M[20:16];

  // Register 0 never carries a dependency, so it is excluded from every match.
  assign e_hit       = (e_dest != 5'd0) &&
                       ((d_use_rs && e_dest == d_rs) || (d_use_rt && e_dest == d_rt));
  assign e_ld_rs_hit = (e_rt != 5'd0) && d_use_rs && (e_rt == d_rs);
  assign e_ld_rt_hit = (e_rt != 5'd0) && d_use_rt && (e_rt == d_rt);
  assign m_hit       = (m_rt != 5'd0) &&
                       ((d_use_rs && m_rt == d_rs) || (d_use_rt && m_rt == d_rt));

  assign stall_a = d_ctrl && (IR_E[31:26] != 6'h03) && e_hit;
  assign stall_b = d_ctrl && is_ld(IR_M) && m_hit;
  // A store whose only dependency is its data register gets that data forwarded in M.
  assign stall_c = is_ld(IR_E) && (e_ld_rs_hit || (e_ld_rt_hit && !d_st));

  assign stall = stall_a || stall_b || stall_c;
  assign pc_en = ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      IR_D  <= NOP_WORD;
      IR_E  <= NOP_WORD;
      IR_M  <= NOP_WORD;
      IR_W  <= NOP_WORD;
      PC8_D <= '0;
      PC8_E <= '0;
      PC8_M <= '0;
      PC8_W <= '0;
    end else begin
      if (stall) begin
        IR_E  <= NOP_WORD;
        PC8_E <= '0;
      end else begin
        IR_D  <= IR_F;
        PC8_D <= PC8_F;
        IR_E  <= IR_D;
        PC8_E <= PC8_D;
      end
      IR_M  <= IR_E;
      PC8_M <= PC8_E;
      IR_W  <= IR_M;
      PC8_W <= PC8_M;
    end
  end

`ifdef STALL_COUNTER_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && stall_cnt != 32'hFFFFFFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
